// File: rtl/seq_mult_pkg.sv
// ============================================================================
// seq_mult_pkg : shared FSM state type and width helpers for seq_csa_mult
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_csa_mult_csa_row.sv
// ============================================================================
// fa_cell / csa_row : single-bit full adder and N-bit 3:2 compressor row
// Rev 1.0
// ============================================================================
`default_nettype none

module fa_cell (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ z;
   assign co = (x & y) | (x & z) | (y & z);
endmodule

// Carry is returned unshifted; the parent applies the weight shift.
module csa_row #(
   parameter int N = 16
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic [N-1:0] z,
   output logic [N-1:0] sum,
   output logic [N-1:0] carry
);
   generate
      for (genvar i = 0; i < N; i++) begin : g_bit
         fa_cell u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .z  (z[i]),
            .s  (sum[i]),
            .co (carry[i])
         );
      end
   endgenerate
endmodule

`default_nettype wire

// File: rtl/seq_csa_mult.sv
// ============================================================================
// seq_csa_mult : iterative carry-save WIDTH x WIDTH multiplier, valid/ready
// Optional macro SIGNED_MODE_EN adds the tc port (two's-complement mode).
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_csa_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef SIGNED_MODE_EN
   input  logic                      tc,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [prod_w(WIDTH)-1:0]  product
);

   localparam int             PW   = prod_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t            state, state_nxt;
   logic [PW-1:0]     a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic [PW-1:0]     s_reg, c_reg;
   logic [CNT_W-1:0]  idx;
   logic [PW-1:0]     pp, pp_row, row_sum, row_carry;
   logic [PW-1:0]     a_ext;
   logic              invert_row, cin;
   logic              accept;

   assign accept = in_valid && (state == IDLE);

`ifdef SIGNED_MODE_EN
   logic tc_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      tc_reg <= 1'b0;
      else if (accept) tc_reg <= tc;
   end
   assign a_ext      = {{WIDTH{tc & a[WIDTH-1]}}, a};
   // Negative-weight MSB row: ~P here plus cin=1 at resolve subtracts P.
   assign invert_row = tc_reg && (idx == LAST);
   assign cin        = tc_reg;
`else
   assign a_ext      = {{WIDTH{1'b0}}, a};
   assign invert_row = 1'b0;
   assign cin        = 1'b0;
`endif

   assign pp     = (a_reg & {PW{b_reg[idx]}}) << idx;
   assign pp_row = invert_row ? ~pp : pp;

   csa_row #(.N(PW)) u_row (
      .x     (s_reg),
      .y     (c_reg),
      .z     (pp_row),
      .sum   (row_sum),
      .carry (row_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)      state_nxt = ACCUM;
         ACCUM:   if (idx == LAST)   state_nxt = RESOLVE;
         RESOLVE:                    state_nxt = DONE;
         DONE:    if (out_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         s_reg   <= '0;
         c_reg   <= '0;
         idx     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_reg <= a_ext;
               b_reg <= b;
               s_reg <= '0;
               c_reg <= '0;
               idx   <= '0;
            end
            ACCUM: begin
               s_reg <= row_sum;
               c_reg <= row_carry << 1;
               idx   <= idx + 1'b1;
            end
            RESOLVE: product <= s_reg + c_reg + PW'(cin);
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_csa_mult.sv
// Scoreboard bench for seq_csa_mult: WIDTH=8 directed/random and WIDTH=16 random with stalls.
`default_nettype none

module tb_seq_csa_mult;

   localparam bit SIGNED =
`ifdef SIGNED_MODE_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, or8, tc8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv16, ir16, ov16, or16, tc16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] q8[$];
   logic [63:0] q16[$];
   int accepts16 = 0;
   int results16 = 0;
   bit stall_en = 1'b0;

   seq_csa_mult #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SIGNED_MODE_EN
      .tc        (tc8),
`endif
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .out_valid (ov8),
      .out_ready (or8),
      .product   (p8)
   );

   seq_csa_mult #(.WIDTH(16)) u_dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SIGNED_MODE_EN
      .tc        (tc16),
`endif
      .in_valid  (iv16),
      .in_ready  (ir16),
      .a         (a16),
      .b         (b16),
      .out_valid (ov16),
      .out_ready (or16),
      .product   (p16)
   );

   // Reference: plain integer multiply, signed interpretation when tc applies.
   function automatic logic [63:0] ref_mult(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input bit t);
      longint sx, sy;
      logic [63:0] m;
      m  = (64'd1 << (2 * w)) - 64'd1;
      sx = longint'(x);
      sy = longint'(y);
      if (t && SIGNED) begin
         if (x[w-1]) sx = sx - (longint'(1) << w);
         if (y[w-1]) sy = sy - (longint'(1) << w);
      end
      return 64'(sx * sy) & m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Monitors: pop and compare whenever a product is handed over.
   always @(negedge clk) begin
      if (rst_n && ov8 && or8) begin
         if (q8.size() == 0) timeout("unexpected_out8");
         else check("prod8", {48'd0, p8}, q8.pop_front());
      end
      if (rst_n && ov16 && or16) begin
         results16++;
         if (q16.size() == 0) timeout("unexpected_out16");
         else check("prod16", {32'd0, p16}, q16.pop_front());
      end
   end

   always @(posedge clk) begin
      if (stall_en) begin
         #1;
         or16 = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send8(input logic [7:0] x, input logic [7:0] y, input bit t);
      int n;
      iv8 = 1'b1; a8 = x; b8 = y; tc8 = t;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ir8 && n < 100);
      if (!ir8) begin
         timeout("accept8");
      end else begin
         q8.push_back(ref_mult(8, {56'd0, x}, {56'd0, y}, t));
         @(posedge clk);
      end
      #1;
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
   endtask

   task automatic send16(input logic [15:0] x, input logic [15:0] y, input bit t);
      int n;
      iv16 = 1'b1; a16 = x; b16 = y; tc16 = t;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ir16 && n < 200);
      if (!ir16) begin
         timeout("accept16");
      end else begin
         q16.push_back(ref_mult(16, {48'd0, x}, {48'd0, y}, t));
         accepts16++;
         @(posedge clk);
      end
      #1;
      iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); tc16 = 1'($urandom);
   endtask

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (q8.size() != 0) timeout("drain8");
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin
      int lat;
      int n;
      iv8 = 0; or8 = 1; tc8 = 0; a8 = 0; b8 = 0;
      iv16 = 0; or16 = 1; tc16 = 0; a16 = 0; b16 = 0;
      #12;
      check("rst_in_ready8", {63'd0, ir8}, 64'd1);
      check("rst_out_valid8", {63'd0, ov8}, 64'd0);
      check("rst_product8", {48'd0, p8}, 64'd0);
      check("rst_in_ready16", {63'd0, ir16}, 64'd1);
      check("rst_out_valid16", {63'd0, ov16}, 64'd0);
      check("rst_product16", {32'd0, p16}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero multiplicand, latency from accept edge.
      send8(8'h00, 8'hB7, 1'b0);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ov8 && lat < 50);
      check("latency8", 64'(lat), 64'd9);
      drain8();

      send8(8'hFF, 8'hFF, 1'b0);
      drain8();
      send8(8'h80, 8'h80, 1'b1);
      send8(8'hFF, 8'h02, 1'b1);
      send8(8'hFF, 8'h02, 1'b0);
      drain8();

      // Back-pressure with a competing in_valid during DONE.
      or8 = 1'b0;
      send8(8'h0D, 8'h0B, 1'b0);
      n = 0;
      while (!ov8 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ov8) timeout("bp_wait");
      iv8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
      repeat (5) begin
         @(negedge clk);
         check("bp_product", {48'd0, p8}, 64'h008F);
         check("bp_out_valid", {63'd0, ov8}, 64'd1);
         check("bp_in_ready", {63'd0, ir8}, 64'd0);
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      or8 = 1'b1;
      drain8();
      repeat (2) @(posedge clk);
      #1;
      check("bp_no_queue_ready", {63'd0, ir8}, 64'd1);
      check("bp_no_queue_valid", {63'd0, ov8}, 64'd0);

      // Asynchronous reset in the middle of accumulation.
      send8(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'd0, ov8}, 64'd0);
      check("arst_in_ready", {63'd0, ir8}, 64'd1);
      q8.delete();
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send8(8'd3, 8'd5, 1'b0);
      drain8();
      check("arst_next_op", {48'd0, p8}, 64'h000F);

      for (int i = 0; i < 30; i++) send8(8'($urandom), 8'($urandom), 1'($urandom));
      drain8();

      // WIDTH=16: back-to-back random operations with random consumer stalls.
      stall_en = 1'b1;
      for (int i = 0; i < 1000; i++) send16(16'($urandom), 16'($urandom), 1'($urandom));
      n = 0;
      while (q16.size() != 0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      if (q16.size() != 0) timeout("drain16");
      stall_en = 1'b0;
      @(posedge clk); #2;
      or16 = 1'b1;
      check("accepts_eq_results16", 64'(results16), 64'(accepts16));
      check("accepts16_total", 64'(accepts16), 64'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
